tx_byte_fifo: RTL and testbench
===============================

# tx_byte_fifo

Byte buffer between the PRINT formatter and `uart_tx`. Accepts bytes on a valid/ready input and stores them in a FIFO of `DEPTH` entries. Presents them one at a time to `uart_tx` on the `d_tx`/`vld_tx`/`rdy_tx` handshake, optionally inserting a carriage return (0x0D) before every line feed (0x0A). This decouples PRINT's bursts, such as a word printed as eight hex characters plus `_`, from the serial bit rate, and flags dropped bytes.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries; power of two, 2..256.
- `CRLF_EN`, default 1: when 1, emit 0x0D before each 0x0A.

Ports:
- `clk`  in  1: the single clock of the block.
- `rst`  in  1: reset, synchronous and active-high.
- `d_in`  in  8: byte from PRINT.
- `vld_in`  in  1: `d_in` valid.
- `rdy_in`  out  1: FIFO can accept; equals `count < DEPTH`.
- `d_tx`  out  8: byte to `uart_tx`.
- `vld_tx`  out  1: `d_tx` valid (to `uart_tx`).
- `rdy_tx`  in  1: `uart_tx` idle and able to take a byte.
- `count`  out  $clog2(DEPTH)+1: entries held in FIFO memory; excludes the byte in the output register.
- `empty`  out  1: `count == 0` and `vld_tx == 0`.
- `ovf`  out  1: sticky; a byte was offered while `rdy_in == 0`.
- `ovf_clr`  in  1: clears `ovf`.

## Operation
- **Push:** at a clock edge where `vld_in && rdy_in`, write `d_in` at `wptr`, `wptr++` mod DEPTH, `count++`.
- **Full:** when `count == DEPTH`, `rdy_in = 0`, even if a pop happens in the same cycle. No push while full.
- **Overflow:** `vld_in && !rdy_in` at an edge sets `ovf`. The byte is discarded and FIFO contents are untouched.
  - `ovf_clr` clears `ovf`.
  - If a set and `ovf_clr` occur in the same cycle, set wins.
- **Output register FSM** (`d_tx`, `vld_tx`), three states:
  - OUT_IDLE: `vld_tx = 0`.
    - If `count > 0` and the head byte is 0x0A with `CRLF_EN = 1`: load 0x0D and go to OUT_CR. No pop.
    - Else if `count > 0`: load the head byte, pop, go to OUT_DATA.
  - OUT_CR: `vld_tx = 1`, `d_tx = 0x0D`. On `vld_tx && rdy_tx`, load the head byte (0x0A), pop, go to OUT_DATA.
  - OUT_DATA: `vld_tx = 1`. On `vld_tx && rdy_tx`, take the next byte directly if `count > 0`, applying the same CR rule as OUT_IDLE and going to OUT_CR or OUT_DATA. Otherwise go to OUT_IDLE.
- **Pop:** `rptr++` mod DEPTH, `count--`. If a push and a pop occur in the same cycle, `count` is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. `count` distinguishes full from empty.
- `d_tx` is held stable while `vld_tx = 1` and `rdy_tx = 0`.

## Timing
- **Reset values:** `vld_tx = 0`, `d_tx = 0x00`, `rdy_in = 1`, `count = 0`, `empty = 1`, `ovf = 0`; state OUT_IDLE; pointers 0. FIFO memory is not cleared.
- **Reset mid-operation:** all queued bytes are discarded. `vld_tx` drops after the reset edge.
- **Latency:** a push at edge N into an empty FIFO in OUT_IDLE gives `vld_tx = 1` after edge N+1. If that byte is 0x0A with `CRLF_EN = 1`, 0x0D appears after edge N+1.
- **Handshake:** a transfer occurs at each edge where `vld_tx && rdy_tx`.
  - `uart_tx` drops `rdy_tx` the cycle after it accepts. No byte is issued twice.
  - Back-to-back transfers are allowed whenever `rdy_tx` stays high.
- **Output timing:** `rdy_in`, `empty` and `count` are registered-state decodes with no combinational path from `vld_in`. `rdy_in` does not depend on `rdy_tx`.

## Structure
- Shared package `uart_pkg`: `CHAR_CR = 8'h0D`, `CHAR_LF = 8'h0A`, `CHAR_US = 8'h5F`, and the output-state enum (OUT_IDLE, OUT_CR, OUT_DATA).
- One sub-module, `sync_fifo_mem`: a DEPTH×8 register array with write port and asynchronous read of `rptr`. Pointers, count and FSM stay in the top level.

## Test plan
- **Single push:** after reset, push 0x41 with `rdy_tx` tied to 1 → `vld_tx = 1`, `d_tx = 0x41` one cycle after the push. Next cycle `vld_tx = 0`, `empty = 1`.
- **Fill:** hold `rdy_tx = 0` and push 17 bytes 0x30..0x40 with DEPTH = 16 → first byte in the output register, `count = 16`, `rdy_in = 0`.
  - Offer 0x99 → `ovf = 1`; 0x99 is never emitted.
  - Pulse `ovf_clr` → `ovf = 0`.
- **CRLF:** with `CRLF_EN = 1`, push 0x31, 0x0A, 0x32 → `d_tx` sequence 0x31, 0x0D, 0x0A, 0x32.
  - With `CRLF_EN = 0` → 0x31, 0x0A, 0x32.
- **End-to-end:** connect `uart_tx` and push "1234_ABCD" (9 bytes) → `txd` carries 9 frames in order, with no duplicates and no gaps beyond the `uart_tx` idle cycle.
- **Wrap-around:** push and pop simultaneously for 40 cycles at `count = 5` → `count` stays 5, pointers wrap, byte order is preserved.
- **Reset mid-operation:** assert `rst` with `count = 7` and `vld_tx = 1` → after the edge, `count = 0`, `vld_tx = 0`, `rdy_in = 1`, `ovf = 0`.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared constants and types for the UART transmit path.
//   CHAR_CR / CHAR_LF / CHAR_US : control and separator characters.
//   out_state_e                 : states of the tx_byte_fifo output register.
package uart_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_US = 8'h5F;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,  // output register empty
    OUT_CR   = 2'd1,  // presenting an inserted CR; the LF is still at the FIFO head
    OUT_DATA = 2'd2   // presenting a byte already popped from the FIFO
  } out_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
// DEPTH x 8 storage for tx_byte_fifo. The write is synchronous and the read
// is asynchronous, so the FIFO head is visible in the same cycle as the read
// pointer that selects it. Contents are never cleared.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : data stored at raddr
module sync_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo
// Byte buffer between the PRINT formatter and uart_tx. Bytes enter on a
// valid/ready port, are queued in a DEPTH-entry FIFO and leave one at a time
// through an output register on the d_tx/vld_tx/rdy_tx handshake. With
// CRLF_EN set, a CR is emitted ahead of every LF. Bytes offered while full
// are dropped and flagged on the sticky ovf output.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   d_in, vld_in      : input byte and its valid
//   rdy_in            : FIFO can accept (count < DEPTH)
//   d_tx, vld_tx      : output byte register and its valid
//   rdy_tx            : downstream can take a byte
//   count             : entries in FIFO memory (output register excluded)
//   empty             : nothing in memory and nothing presented
//   ovf, ovf_clr      : sticky overflow flag and its clear
module tx_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter bit CRLF_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             d_in,
  input  logic                   vld_in,
  output logic                   rdy_in,
  output logic [7:0]             d_tx,
  output logic                   vld_tx,
  input  logic                   rdy_tx,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  out_state_e    state_q, state_d;
  logic [7:0]    d_tx_q, d_tx_d;
  logic          ovf_q, ovf_d;

  logic          push;
  logic          pop;
  logic          take_next;
  logic          has_head;
  logic [7:0]    head;

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (d_in),
    .raddr (rptr_q),
    .rdata (head)
  );

  // Full is decoded from count alone so a same-cycle pop never opens the
  // input; this keeps rdy_in free of any path from rdy_tx.
  assign rdy_in   = (count_q != DEPTH_C);
  assign push     = vld_in && rdy_in;
  assign has_head = (count_q != '0);

  // Output register FSM.
  always_comb begin
    state_d   = state_q;
    d_tx_d    = d_tx_q;
    pop       = 1'b0;
    take_next = 1'b0;

    case (state_q)
      OUT_IDLE: begin
        take_next = has_head;
      end
      OUT_CR: begin
        // The LF was left at the head while the CR went out; send it now.
        if (rdy_tx) begin
          d_tx_d  = head;
          pop     = 1'b1;
          state_d = OUT_DATA;
        end
      end
      OUT_DATA: begin
        if (rdy_tx) begin
          take_next = has_head;
          if (!has_head) begin
            state_d = OUT_IDLE;
          end
        end
      end
      default: begin
        state_d = OUT_IDLE;
      end
    endcase

    if (take_next) begin
      if (CRLF_EN && (head == CHAR_LF)) begin
        d_tx_d  = CHAR_CR;
        state_d = OUT_CR;
      end else begin
        d_tx_d  = head;
        pop     = 1'b1;
        state_d = OUT_DATA;
      end
    end
  end

  // Pointers, occupancy and overflow flag.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new overflow takes priority over a clear in the same cycle.
    if (vld_in && !rdy_in) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= OUT_IDLE;
      d_tx_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
      d_tx_q  <= d_tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign d_tx   = d_tx_q;
  assign vld_tx = (state_q != OUT_IDLE);
  assign count  = count_q;
  assign empty  = (count_q == '0) && (state_q == OUT_IDLE);
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_tx_byte_fifo.sv
module tb_tx_byte_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic       vld_in = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       man_rdy = 1'b0;
  logic       sink_rdy = 1'b1;
  logic       sink_mode = 1'b0;
  logic       rdy_tx;

  assign rdy_tx = sink_mode ? sink_rdy : man_rdy;

  // Instance with CR insertion enabled
  logic       rdy_in_a, vld_tx_a, empty_a, ovf_a;
  logic [7:0] d_tx_a;
  logic [4:0] count_a;
  // Instance with CR insertion disabled
  logic       rdy_in_b, vld_tx_b, empty_b, ovf_b;
  logic [7:0] d_tx_b;
  logic [4:0] count_b;

  tx_byte_fifo #(.DEPTH(DEPTH), .CRLF_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .d_in(d_in), .vld_in(vld_in), .rdy_in(rdy_in_a),
    .d_tx(d_tx_a), .vld_tx(vld_tx_a), .rdy_tx(rdy_tx), .count(count_a),
    .empty(empty_a), .ovf(ovf_a), .ovf_clr(ovf_clr)
  );

  tx_byte_fifo #(.DEPTH(DEPTH), .CRLF_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .d_in(d_in), .vld_in(vld_in), .rdy_in(rdy_in_b),
    .d_tx(d_tx_b), .vld_tx(vld_tx_b), .rdy_tx(rdy_tx), .count(count_b),
    .empty(empty_b), .ovf(ovf_b), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic xfer_a = 1'b0;
  int sink_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever vld_tx and
  // rdy_tx are both high here; pop the expected byte and compare.
  always @(negedge clk) begin
    logic [7:0] e;
    xfer_a = 1'b0;
    if (!rst && vld_tx_a && rdy_tx) begin
      xfer_a = 1'b1;
      if (q_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_crlf1: got %02h expected no byte", d_tx_a);
      end else begin
        e = q_a.pop_front();
        check("out_crlf1", 32'(d_tx_a), 32'(e));
        $display("tx crlf1 byte=%02h expected=%02h", d_tx_a, e);
      end
    end
    if (!rst && vld_tx_b && rdy_tx) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_crlf0: got %02h expected no byte", d_tx_b);
      end else begin
        e = q_b.pop_front();
        check("out_crlf0", 32'(d_tx_b), 32'(e));
        $display("tx crlf0 byte=%02h expected=%02h", d_tx_b, e);
      end
    end
  end

  // uart_tx-like sink: ready drops for three cycles after each accepted byte.
  always @(posedge clk) begin
    #1;
    if (!sink_mode) begin
      sink_rdy  = 1'b1;
      sink_busy = 0;
    end else if (xfer_a) begin
      sink_rdy  = 1'b0;
      sink_busy = 3;
    end else if (sink_busy > 0) begin
      sink_busy--;
      if (sink_busy == 0) sink_rdy = 1'b1;
    end
  end

  // Offer one byte; accept says whether the FIFO must take it.
  task automatic push_byte(input logic [7:0] b, input bit accept);
    d_in   = b;
    vld_in = 1'b1;
    @(negedge clk);
    check("rdy_in", 32'(rdy_in_a), 32'(accept));
    if (accept) begin
      if (b == 8'h0A) q_a.push_back(8'h0D);
      q_a.push_back(b);
      q_b.push_back(b);
    end
    @(posedge clk);
    #1;
    vld_in = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || !empty_a || !empty_b) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_in_time", 32'(n < budget), 32'd1);
    check("empty_after_drain", 32'(empty_a), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_vld_tx", 32'(vld_tx_a), 32'd0);
    check("rst_d_tx", 32'(d_tx_a), 32'h00);
    check("rst_rdy_in", 32'(rdy_in_a), 32'd1);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_empty", 32'(empty_a), 32'd1);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    @(posedge clk);
    #1;

    // Single push, latency one cycle
    man_rdy = 1'b1;
    push_byte(8'h41, 1'b1);
    @(negedge clk);
    check("single_pre_vld", 32'(vld_tx_a), 32'd0);
    @(negedge clk);
    check("single_vld", 32'(vld_tx_a), 32'd1);
    check("single_d_tx", 32'(d_tx_a), 32'h41);
    @(negedge clk);
    check("single_post_vld", 32'(vld_tx_a), 32'd0);
    check("single_post_empty", 32'(empty_a), 32'd1);
    @(posedge clk);
    #1;

    // Fill: 17 bytes with downstream stalled
    man_rdy = 1'b0;
    for (int i = 0; i < 17; i++) push_byte(8'(8'h30 + i), 1'b1);
    check("fill_count", 32'(count_a), 32'd16);
    check("fill_rdy_in", 32'(rdy_in_a), 32'd0);
    check("fill_vld_tx", 32'(vld_tx_a), 32'd1);
    check("fill_d_tx", 32'(d_tx_a), 32'h30);
    push_byte(8'h99, 1'b0);
    check("ovf_set", 32'(ovf_a), 32'd1);
    check("ovf_count", 32'(count_a), 32'd16);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf_a), 32'd0);
    // Overflow and clear together: set wins
    d_in    = 8'h99;
    vld_in  = 1'b1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    vld_in  = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf_a), 32'd1);
    check("ovf_set_wins_count", 32'(count_a), 32'd16);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    man_rdy = 1'b1;
    drain(200);

    // CRLF insertion
    push_byte(8'h31, 1'b1);
    push_byte(8'h0A, 1'b1);
    push_byte(8'h32, 1'b1);
    drain(100);
    push_byte(8'h0A, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("lf_from_idle_cr", 32'(d_tx_a), 32'h0D);
    check("lf_from_idle_plain", 32'(d_tx_b), 32'h0A);
    drain(100);

    // Wrap-around: simultaneous push/pop with five entries held
    man_rdy = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'(8'h80 + i), 1'b1);
    check("wrap_start_count", 32'(count_a), 32'd5);
    man_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_byte(8'(8'h86 + i), 1'b1);
      check("wrap_count", 32'(count_a), 32'd5);
    end
    drain(200);

    // Reset mid-operation
    man_rdy = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'(8'hC0 + i), 1'b1);
    check("midrst_pre_count", 32'(count_a), 32'd7);
    check("midrst_pre_vld", 32'(vld_tx_a), 32'd1);
    rst = 1'b1;
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_count", 32'(count_a), 32'd0);
    check("midrst_vld", 32'(vld_tx_a), 32'd0);
    check("midrst_rdy_in", 32'(rdy_in_a), 32'd1);
    check("midrst_ovf", 32'(ovf_a), 32'd0);
    check("midrst_empty", 32'(empty_a), 32'd1);
    man_rdy = 1'b1;
    push_byte(8'h55, 1'b1);
    drain(100);

    // End-to-end against a paced sink
    sink_mode = 1'b1;
    s = "1234_ABCD";
    for (int i = 0; i < s.len(); i++) push_byte(s[i], 1'b1);
    drain(600);
    sink_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
